// File: rtl/iter_alu.sv
// ---------------------------------------------------------------------------
// iter_alu
// Small EX-stage ALU with single-cycle logic/arithmetic/shift operations and
// an iterative shift-add multiplier that retires MUL_STEP multiplier bits per
// cycle. Every result is registered and announced by a one-cycle valid pulse.
//
// Ports
//   clk_i      : clock, all state changes on the rising edge
//   rst_i      : synchronous active-high reset
//   valid_i    : operation request from the EX stage
//   flush_i    : pipeline flush, blocks accepts and aborts a running multiply
//   ALUCtrl_i  : 4-bit operation code
//   data1_i    : operand A (rs1)
//   data2_i    : operand B (rs2 or immediate)
//   data_o     : registered result
//   valid_o    : one-cycle pulse, data_o carries a new result
//   zero_o     : registered flag, high when data_o == 0
//   busy_o     : multiply in flight, upstream must hold its request
//   illegal_o  : one-cycle pulse with valid_o for an unrecognised code
// ---------------------------------------------------------------------------
module iter_alu #(
    parameter int MUL_STEP = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic        flush_i,
    input  logic [3:0]  ALUCtrl_i,
    input  logic [31:0] data1_i,
    input  logic [31:0] data2_i,
    output logic [31:0] data_o,
    output logic        valid_o,
    output logic        zero_o,
    output logic        busy_o,
    output logic        illegal_o
);

    localparam int N  = 32 / MUL_STEP;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_XOR  = 4'b0001;
    localparam logic [3:0] OP_SLL  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_MUL  = 4'b0101;
    localparam logic [3:0] OP_SRAI = 4'b0111;

    typedef enum logic {
        IDLE,
        MUL_RUN
    } state_e;

    state_e        state_q, state_d;
    logic          pend_q, pend_d;
    logic [3:0]    op_q, op_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    logic [31:0]   acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   data_q, data_d;
    logic          zero_q, zero_d;
    logic          valid_q, valid_d;
    logic          illegal_q, illegal_d;

    logic          accept;
    logic [31:0]   singleRes;
    logic          singleIll;
    logic [31:0]   mulAccNext;
    logic [31:0]   mulANext;
    logic [31:0]   mulBNext;

    // The multiplier stays busy until its last iteration is due, so the
    // request held upstream is taken at the same edge the product is written.
    assign busy_o = (state_q == MUL_RUN) && (cnt_q != LAST_ITER);
    assign accept = valid_i && !busy_o && !flush_i && !rst_i;

    // Result of the single-cycle operation latched at the previous accept.
    always_comb begin
        singleRes = 32'h0;
        singleIll = 1'b0;
        case (op_q)
            OP_AND:  singleRes = a_q & b_q;
            OP_XOR:  singleRes = a_q ^ b_q;
            OP_SLL:  singleRes = a_q << b_q[4:0];
            OP_ADD:  singleRes = a_q + b_q;
            OP_SUB:  singleRes = a_q - b_q;
            OP_SRAI: singleRes = $unsigned($signed(a_q) >>> b_q[4:0]);
            default: singleIll = 1'b1;
        endcase
    end

    // One multiply iteration: a_q is the shifted multiplicand, b_q the
    // remaining multiplier bits, consumed LSB first.
    always_comb begin
        mulAccNext = acc_q;
        mulANext   = a_q;
        mulBNext   = b_q;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (mulBNext[0]) begin
                mulAccNext = mulAccNext + mulANext;
            end
            mulANext = mulANext << 1;
            mulBNext = mulBNext >> 1;
        end
    end

    // Next-state logic: finish pending work first, then take a new request.
    // A new accept may reuse the operand registers at the edge where the
    // multiply finishes, because its last iteration has already been folded
    // into the product.
    always_comb begin
        state_d   = state_q;
        pend_d    = 1'b0;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        zero_d    = zero_q;
        valid_d   = 1'b0;
        illegal_d = 1'b0;

        // An already accepted single-cycle op is written even under flush.
        if (pend_q) begin
            data_d    = singleRes;
            zero_d    = (singleRes == 32'h0);
            valid_d   = 1'b1;
            illegal_d = singleIll;
        end

        if (state_q == MUL_RUN) begin
            if (flush_i) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else if (cnt_q == LAST_ITER) begin
                state_d = IDLE;
                cnt_d   = '0;
                acc_d   = mulAccNext;
                data_d  = mulAccNext;
                zero_d  = (mulAccNext == 32'h0);
                valid_d = 1'b1;
            end else begin
                acc_d = mulAccNext;
                a_d   = mulANext;
                b_d   = mulBNext;
                cnt_d = cnt_q + CW'(1);
            end
        end

        if (accept) begin
            op_d  = ALUCtrl_i;
            a_d   = data1_i;
            b_d   = data2_i;
            cnt_d = '0;
            if (ALUCtrl_i == OP_MUL) begin
                state_d = MUL_RUN;
                acc_d   = 32'h0;
            end else begin
                pend_d = 1'b1;
            end
        end
    end

    // State registers; reset leaves a zero result with the zero flag set.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            pend_q    <= 1'b0;
            op_q      <= 4'h0;
            a_q       <= 32'h0;
            b_q       <= 32'h0;
            acc_q     <= 32'h0;
            cnt_q     <= '0;
            data_q    <= 32'h0;
            zero_q    <= 1'b1;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            zero_q    <= zero_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
        end
    end

    assign data_o    = data_q;
    assign zero_o    = zero_q;
    assign valid_o   = valid_q;
    assign illegal_o = illegal_q;

endmodule
